// File: rtl/cdb_pkg.sv
// Shared constants, CDB bus type and grant encode/decode helpers for the CDB arbiter.
package cdb_pkg;

    localparam int NREQ       = 4;
    localparam int IDX_INT    = 0;
    localparam int IDX_LDST   = 1;
    localparam int IDX_MULT   = 2;
    localparam int IDX_DIV    = 3;

    localparam int DEF_TAG_W  = 5;
    localparam int DEF_DATA_W = 32;

    typedef struct packed {
        logic                  valid;
        logic [DEF_TAG_W-1:0]  tag;
        logic [DEF_DATA_W-1:0] data;
        logic                  branch;
        logic                  taken;
        logic [1:0]            src;
    } cdb_bus_t;

    // Index to one-hot request vector.
    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // One-hot (or zero) grant to index; zero maps to index 0.
    function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) begin
                idx = idx | 2'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic 4-way round-robin arbiter; pointer advances past whichever index the
// parent actually granted, so external overrides still rotate fairness.
module rr_arbiter
    import cdb_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] upd_gnt,
    output logic [NREQ-1:0] gnt
);

    logic [1:0]        r_ptr;
    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [1:0]        w_off;
    logic [1:0]        w_win;
    logic              w_any;

    assign w_dbl = {req, req} >> r_ptr;
    assign w_rot = w_dbl[NREQ-1:0];
    assign w_any = |req;
    assign w_win = r_ptr + w_off;

    // First requester at or after the pointer, as an offset from the pointer.
    always_comb begin
        w_off = 2'd0;
        casez (w_rot)
            4'b???1: w_off = 2'd0;
            4'b??10: w_off = 2'd1;
            4'b?100: w_off = 2'd2;
            4'b1000: w_off = 2'd3;
            default: w_off = 2'd0;
        endcase
    end

    // Grant output, suppressed while disabled or when nobody requests.
    always_comb begin
        gnt = 4'b0000;
        if (en && w_any) begin
            gnt = idx_to_onehot(w_win);
        end else begin
            gnt = 4'b0000;
        end
    end

    // Pointer moves one past the final grant; holds when nothing is granted.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr <= 2'd0;
        end else if (|upd_gnt) begin
            r_ptr <= onehot_to_idx(upd_gnt) + 2'd1;
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants one completing unit per cycle and registers its
// result onto the CDB. Optional macro CDB_MULT_PRIO_EN gives the multiplier absolute priority.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int TAG_W  = DEF_TAG_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [NREQ-1:0]        Req_valid,
    input  logic [NREQ*TAG_W-1:0]  Req_tag,
    input  logic [NREQ*DATA_W-1:0] Req_data,
    input  logic [NREQ-1:0]        Req_branch,
    input  logic [NREQ-1:0]        Req_taken,
    output logic [NREQ-1:0]        Req_gnt,
    output logic                   Cdb_valid,
    output logic [TAG_W-1:0]       Cdb_rd_tag,
    output logic [DATA_W-1:0]      Cdb_data,
    output logic                   Cdb_branch,
    output logic                   Cdb_branch_taken,
    output logic [1:0]             Cdb_src
);

    logic              w_en;
    logic              w_mult_win;
    logic [NREQ-1:0]   w_rr_gnt;
    logic [NREQ-1:0]   w_gnt;
    logic [1:0]        w_src;
    logic              w_any;
    logic [TAG_W-1:0]  w_tag;
    logic [DATA_W-1:0] w_data;

    logic              r_valid;
    logic [TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_data;
    logic              r_branch;
    logic              r_taken;
    logic [1:0]        r_src;

    // Reset outranks flush, and both silence the grant in their cycle.
    assign w_en = !flush && !reset;

`ifdef CDB_MULT_PRIO_EN
    // The multiplier pipeline cannot stall, so it pre-empts the rotation.
    assign w_mult_win = w_en && Req_valid[IDX_MULT];
`else
    assign w_mult_win = 1'b0;
`endif

    rr_arbiter u_rr (
        .clock   (clock),
        .reset   (reset),
        .en      (w_en),
        .req     (Req_valid),
        .upd_gnt (w_gnt),
        .gnt     (w_rr_gnt)
    );

    // Final grant: mult override when enabled, otherwise the round-robin winner.
    always_comb begin
        w_gnt = 4'b0000;
        if (w_mult_win) begin
            w_gnt = idx_to_onehot(2'(IDX_MULT));
        end else begin
            w_gnt = w_rr_gnt;
        end
    end

    assign Req_gnt = w_gnt;
    assign w_any   = |w_gnt;
    assign w_src   = onehot_to_idx(w_gnt);
    assign w_tag   = Req_tag[w_src*TAG_W +: TAG_W];
    assign w_data  = Req_data[w_src*DATA_W +: DATA_W];

    // CDB broadcast register: loads the granted payload, valid lasts one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_tag    <= '0;
            r_data   <= '0;
            r_branch <= 1'b0;
            r_taken  <= 1'b0;
            r_src    <= 2'd0;
        end else if (w_any) begin
            r_valid  <= 1'b1;
            r_tag    <= w_tag;
            r_data   <= w_data;
            r_branch <= Req_branch[w_src];
            r_taken  <= Req_taken[w_src];
            r_src    <= w_src;
        end else begin
            r_valid  <= 1'b0;
            r_tag    <= r_tag;
            r_data   <= r_data;
            r_branch <= r_branch;
            r_taken  <= r_taken;
            r_src    <= r_src;
        end
    end

    assign Cdb_valid        = r_valid;
    assign Cdb_rd_tag       = r_tag;
    assign Cdb_data         = r_data;
    assign Cdb_branch       = r_branch;
    assign Cdb_branch_taken = r_taken;
    assign Cdb_src          = r_src;

endmodule
